vga_axis_timing: RTL

- Parametrised single-axis VGA timing generator. Owns its position counter and drives a four-phase state machine: SYNC, BACK porch, ACTIVE, FRONT porch.
- The display top instantiates it twice:
  - horizontal: EN tied high, advances every pixel clock.
  - vertical: EN driven by the horizontal WRAP.
- Generates sync, active-video flag, pixel/line position and an end-of-period strobe for cascading.

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/vga_axis_timing.sv | 93 +++++++++
 2 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - phase encoding and 640x480@60 timing defaults for vga_axis_timing
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_BACK   = 2'd1,
        PH_ACTIVE = 2'd2,
        PH_FRONT  = 2'd3
    } phase_t;

    // 640x480@60 horizontal, in pixel clocks
    localparam int H_SYNC_LEN   = 96;
    localparam int H_BACK_LEN   = 48;
    localparam int H_ACTIVE_LEN = 640;
    localparam int H_FRONT_LEN  = 16;

    // 640x480@60 vertical, in lines
    localparam int V_SYNC_LEN   = 2;
    localparam int V_BACK_LEN   = 33;
    localparam int V_ACTIVE_LEN = 480;
    localparam int V_FRONT_LEN  = 10;

endpackage

// File: rtl/vga_axis_timing.sv
// rtl/vga_axis_timing.sv - single-axis VGA timing generator (counter + SYNC/BACK/ACTIVE/FRONT phase)
// Optional PREFETCH decode is built only when VGA_TIMING_PREFETCH_EN is defined.
module vga_axis_timing
    import vga_timing_pkg::*;
#(
    parameter int SYNC_LEN   = H_SYNC_LEN,
    parameter int BACK_LEN   = H_BACK_LEN,
    parameter int ACTIVE_LEN = H_ACTIVE_LEN,
    parameter int FRONT_LEN  = H_FRONT_LEN,
    parameter bit SYNC_POL   = 1'b0,
    parameter int CNT_W      = 10
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    output logic [CNT_W-1:0] CNT,
    output logic [1:0]       STATE,
    output logic             SYNC,
    output logic             ACTIVE,
    output logic [CNT_W-1:0] POS,
    output logic             WRAP,
    output logic             PREFETCH
);

    localparam int TOTAL = SYNC_LEN + BACK_LEN + ACTIVE_LEN + FRONT_LEN;

    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] BACK_END = CNT_W'(SYNC_LEN + BACK_LEN - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(SYNC_LEN + BACK_LEN + ACTIVE_LEN - 1);
    localparam logic [CNT_W-1:0] ACT_BASE = CNT_W'(SYNC_LEN + BACK_LEN);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

    if (SYNC_LEN < 1 || BACK_LEN < 1 || ACTIVE_LEN < 1 || FRONT_LEN < 1) begin : g_len_check
        $error("vga_axis_timing: every phase length must be at least 1");
    end

    if (longint'(TOTAL) > (longint'(1) << CNT_W)) begin : g_width_check
        $error("vga_axis_timing: CNT_W too narrow for the total period");
    end

    phase_t           state_q;
    phase_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= PH_SYNC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (EN) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                PH_SYNC:   if (cnt_q == SYNC_END) state_d = PH_BACK;
                PH_BACK:   if (cnt_q == BACK_END) state_d = PH_ACTIVE;
                PH_ACTIVE: if (cnt_q == ACT_END)  state_d = PH_FRONT;
                PH_FRONT:  state_d = PH_FRONT;
                default:   state_d = PH_SYNC;
            endcase
            // End of period, or a count beyond it, restarts cleanly at SYNC
            if (cnt_q >= LAST) begin
                cnt_d   = '0;
                state_d = PH_SYNC;
            end
        end
    end

    assign CNT    = cnt_q;
    assign STATE  = state_q;
    assign ACTIVE = (state_q == PH_ACTIVE);
    assign SYNC   = (state_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign POS    = ACTIVE ? (cnt_q - ACT_BASE) : '0;
    assign WRAP   = EN && (cnt_q == LAST);

`ifdef VGA_TIMING_PREFETCH_EN
    localparam logic [CNT_W-1:0] PF_LO = CNT_W'(SYNC_LEN + BACK_LEN - 1);
    localparam logic [CNT_W-1:0] PF_HI = CNT_W'(SYNC_LEN + BACK_LEN + ACTIVE_LEN - 2);

    // Leads ACTIVE by one advance so a fetch pipeline can start early
    assign PREFETCH = (cnt_q >= PF_LO) && (cnt_q <= PF_HI);
`else
    assign PREFETCH = 1'b0;
`endif

endmodule
